// File: rtl/mac_pkg.sv
// Shared widths and helpers for the multi-lane MAC datapath.
// The lane-sum width macro keeps the adder tree and accumulator in agreement.
`define MAC_LANE_SUM_WIDTH(dw, lanes) (2*(dw) + mac_pkg::clog2(lanes))

package mac_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_LANES      = 4;
  localparam int DEFAULT_ACC_WIDTH  = 16;

  // Ceiling log2; clog2(1) = 0 so a single-lane build needs no extra sum bits.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/mac_vector_accumulator_if.sv
// Streaming port bundle: input beats (valid/ready/last) and the result channel.
interface mac_vector_accumulator_if
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LANES      = DEFAULT_LANES,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
);

  logic                        in_valid;
  logic                        in_ready;
  logic                        in_last;
  logic [ACC_WIDTH-1:0]        add_value;
  logic [LANES*DATA_WIDTH-1:0] input_values;
  logic [LANES*DATA_WIDTH-1:0] weight_values;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_WIDTH-1:0]        output_value;
  logic                        overflow;

  modport master (
    output in_valid, in_last, add_value, input_values, weight_values, out_ready,
    input  in_ready, out_valid, output_value, overflow
  );

  modport slave (
    input  in_valid, in_last, add_value, input_values, weight_values, out_ready,
    output in_ready, out_valid, output_value, overflow
  );

endinterface

// File: rtl/mac_adder_tree.sv
// Combinational balanced adder tree reducing LANES products to one lane sum.
module mac_adder_tree
  import mac_pkg::*;
#(
  parameter int LANES      = DEFAULT_LANES,
  parameter int PROD_WIDTH = 2 * DEFAULT_DATA_WIDTH,
  parameter int SUM_WIDTH  = PROD_WIDTH + clog2(LANES)
) (
  input  logic [LANES*PROD_WIDTH-1:0] products,
  output logic [SUM_WIDTH-1:0]        sum
);

  localparam int LEAVES = 1 << clog2(LANES);
  localparam int NODES  = 2 * LEAVES - 1;

  // Heap-ordered tree: leaves padded with zero up to a power of two, node n sums 2n+1 and 2n+2.
  function automatic logic [SUM_WIDTH-1:0] tree_sum(input logic [LANES*PROD_WIDTH-1:0] p);
    logic [SUM_WIDTH-1:0] node [NODES];
    for (int i = 0; i < LEAVES; i++) begin
      if (i < LANES) node[LEAVES-1+i] = SUM_WIDTH'(p[i*PROD_WIDTH +: PROD_WIDTH]);
      else           node[LEAVES-1+i] = '0;
    end
    for (int n = LEAVES - 2; n >= 0; n--) node[n] = node[2*n+1] + node[2*n+2];
    return node[0];
  endfunction

  assign sum = tree_sum(products);

endmodule

// File: rtl/mac_vector_accumulator.sv
// Two-stage pipelined multi-lane dot-product accumulator with a global output stall.
// Stage P registers lane products; stage A reduces, accumulates and publishes results.
module mac_vector_accumulator
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LANES      = DEFAULT_LANES,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  mac_vector_accumulator_if.slave  bus
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int SUM_WIDTH  = `MAC_LANE_SUM_WIDTH(DATA_WIDTH, LANES);
  localparam int EXT_WIDTH  = ACC_WIDTH + 1 + clog2(LANES);

  logic                        stall;
  logic                        accept;
  logic                        first_beat;
  logic                        p_valid;
  logic                        p_last;
  logic                        p_first;
  logic [LANES*PROD_WIDTH-1:0] p_products;
  logic [LANES*PROD_WIDTH-1:0] products_next;
  logic [ACC_WIDTH-1:0]        p_bias;
  logic [ACC_WIDTH-1:0]        acc;
  logic                        sticky;
  logic [SUM_WIDTH-1:0]        lane_sum;
  logic [EXT_WIDTH-1:0]        acc_wide;
  logic [ACC_WIDTH-1:0]        acc_next;
  logic                        beat_overflow;
  logic                        vector_overflow;

  // A held result freezes the whole pipeline, so nothing upstream can be lost.
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign accept       = bus.in_valid & ~stall;

  // NOTE: every always_comb output gets a value on every path; a missed default infers a latch.
  always_comb begin
    products_next = '0;
    for (int i = 0; i < LANES; i++) begin
      products_next[i*PROD_WIDTH +: PROD_WIDTH] =
        PROD_WIDTH'(bus.input_values[i*DATA_WIDTH +: DATA_WIDTH]) *
        PROD_WIDTH'(bus.weight_values[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  mac_adder_tree #(
    .LANES      (LANES),
    .PROD_WIDTH (PROD_WIDTH),
    .SUM_WIDTH  (SUM_WIDTH)
  ) u_adder_tree (
    .products (p_products),
    .sum      (lane_sum)
  );

  // Extra headroom bits catch overflow even when the bias is near full scale.
  always_comb begin
    acc_wide        = EXT_WIDTH'(p_first ? p_bias : acc) + EXT_WIDTH'(lane_sum);
    beat_overflow   = |acc_wide[EXT_WIDTH-1:ACC_WIDTH];
    vector_overflow = beat_overflow | (sticky & ~p_first);
    if (SATURATE && beat_overflow) acc_next = '1;
    else                           acc_next = acc_wide[ACC_WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: datapath registers are reset too, so a mid-vector reset can never leak a partial sum.
      first_beat       <= 1'b1;
      p_valid          <= 1'b0;
      p_last           <= 1'b0;
      p_first          <= 1'b1;
      p_products       <= '0;
      p_bias           <= '0;
      acc              <= '0;
      sticky           <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.output_value <= '0;
      bus.overflow     <= 1'b0;
    end else if (!stall) begin
      p_valid <= accept;
      if (accept) begin
        p_products <= products_next;
        p_last     <= bus.in_last;
        p_first    <= first_beat;
        first_beat <= bus.in_last;
        if (first_beat) p_bias <= bus.add_value;
      end

      bus.out_valid <= p_valid & p_last;
      if (p_valid) begin
        if (p_last) begin
          bus.output_value <= acc_next;
          bus.overflow     <= vector_overflow;
          sticky           <= 1'b0;
        end else begin
          acc    <= acc_next;
          sticky <= vector_overflow;
        end
      end
    end
  end

endmodule
